// File: rtl/hub75_rx_capture.sv
// hub75_rx_capture: panel-side HUB75 receiver. Synchronises the bus into clk,
// rebuilds each latched row from the SCLK shifts and drains it as pixel
// writes (upper half first, then lower half) into a frame-buffer memory.
// Optional OE-on-time monitor: define HUB75_OE_MONITOR_EN.
//
// state | meaning
// IDLE  | waiting for a latch with exactly COLS shifts
// DRAIN | one pixel write per cycle, 2*COLS cycles
// DONE  | one cycle; frame_done pulses when the drained row was the last one
module hub75_rx_capture #(
    parameter int COLS        = 32,
    parameter int ROWS_HALF   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        LAT,
    input  logic        OE,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        R0,
    input  logic        G0,
    input  logic        B0,
    input  logic        R1,
    input  logic        G1,
    input  logic        B1,
    output logic        pix_we,
    output logic [9:0]  pix_addr,
    output logic [2:0]  pix_rgb,
    output logic        frame_done,
    output logic        col_err,
    output logic        ovr_err,
    output logic [15:0] oe_on_cycles
);

    localparam int NSYNC  = 13;
    localparam int CNT_W  = $clog2(COLS + 2);
    localparam int SLOT_W = $clog2(COLS);
    localparam int DRN_W  = $clog2(2 * COLS);
    localparam int LINE_W = $clog2(2 * ROWS_HALF);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [DRN_W-1:0]   drn_q, drn_d;

    logic [NSYNC-1:0]   sync_q [SYNC_STAGES];
    logic [NSYNC-1:0]   bus_s;
    logic               sclk_s, lat_s, oe_s;
    logic [3:0]         row_in;
    logic [5:0]         word_in;
    logic               sclk_prev_q, lat_prev_q;
    logic               sclk_rise, lat_rise;

    logic [5:0]         shift_buf_q [COLS];
    logic [5:0]         shift_buf_d [COLS];
    logic [5:0]         drain_buf_q [COLS];
    logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d, shift_cnt_eff;
    logic [3:0]         row_q;
    logic               row_ok, lat_take, lat_ovr, lat_bad;
    logic               col_err_q, ovr_err_q;

    logic               lower;
    logic [SLOT_W-1:0]  col;
    logic [5:0]         rd_word;
    logic [LINE_W-1:0]  line;
    logic [9:0]         addr_live, addr_hold_q;
    logic [2:0]         rgb_live, rgb_hold_q;

    assign bus_s   = sync_q[SYNC_STAGES-1];
    assign sclk_s  = bus_s[12];
    assign lat_s   = bus_s[11];
    assign oe_s    = bus_s[10];
    assign row_in  = bus_s[9:6];
    assign word_in = bus_s[5:0];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign lat_rise  = lat_s & ~lat_prev_q;

    // Synchronise every bus input and keep the previous samples for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sclk_prev_q <= 1'b0;
            lat_prev_q  <= 1'b0;
        end else begin
            sync_q[0] <= {SCLK, LAT, OE, D, C, B, A, R0, G0, B0, R1, G1, B1};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_prev_q <= sclk_s;
            lat_prev_q  <= lat_s;
        end
    end

    // Apply a same-cycle shift before judging the latch, then classify the latch
    always_comb begin
        shift_buf_d   = shift_buf_q;
        shift_cnt_eff = shift_cnt_q;
        if (sclk_rise) begin
            if (shift_cnt_q < CNT_W'(COLS))
                shift_buf_d[shift_cnt_q[SLOT_W-1:0]] = word_in;
            if (shift_cnt_q < CNT_W'(COLS + 1))
                shift_cnt_eff = shift_cnt_q + CNT_W'(1);
        end
        shift_cnt_d = lat_rise ? '0 : shift_cnt_eff;
        row_ok      = lat_rise && (shift_cnt_eff == CNT_W'(COLS));
        lat_take    = row_ok && (state_q == IDLE);
        lat_ovr     = row_ok && (state_q != IDLE);
        lat_bad     = lat_rise && !row_ok;
    end

    // Shift buffer, drain-buffer snapshot on an accepted latch, error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COLS; i++) begin
                shift_buf_q[i] <= '0;
                drain_buf_q[i] <= '0;
            end
            shift_cnt_q <= '0;
            row_q       <= '0;
            col_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            shift_buf_q <= shift_buf_d;
            shift_cnt_q <= shift_cnt_d;
            if (lat_take) begin
                drain_buf_q <= shift_buf_d;
                row_q       <= row_in;
            end
            col_err_q <= lat_bad;
            ovr_err_q <= lat_ovr;
        end
    end

    // FSM state and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            drn_q   <= drn_d;
        end
    end

    // FSM next state, write strobe and frame pulse
    always_comb begin
        state_d    = state_q;
        drn_d      = drn_q;
        pix_we     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (lat_take) begin
                    state_d = DRAIN;
                    drn_d   = '0;
                end
            end
            DRAIN: begin
                pix_we = 1'b1;
                if (drn_q == DRN_W'(2 * COLS - 1)) state_d = DONE;
                else drn_d = drn_q + DRN_W'(1);
            end
            DONE: begin
                frame_done = (row_q == 4'(ROWS_HALF - 1));
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain address/colour; shift k sits in column COLS-1-k
    always_comb begin
        lower     = (drn_q >= DRN_W'(COLS));
        col       = lower ? SLOT_W'(drn_q - DRN_W'(COLS)) : SLOT_W'(drn_q);
        rd_word   = drain_buf_q[SLOT_W'(COLS - 1) - col];
        line      = lower ? LINE_W'(row_q) + LINE_W'(ROWS_HALF) : LINE_W'(row_q);
        addr_live = 10'(line) * 10'(COLS) + 10'(col);
        rgb_live  = lower ? rd_word[2:0] : rd_word[5:3];
    end

    // Remember the last written pixel so the bus holds between bursts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold_q <= '0;
            rgb_hold_q  <= '0;
        end else if (state_q == DRAIN) begin
            addr_hold_q <= addr_live;
            rgb_hold_q  <= rgb_live;
        end
    end

    assign pix_addr = (state_q == DRAIN) ? addr_live : addr_hold_q;
    assign pix_rgb  = (state_q == DRAIN) ? rgb_live  : rgb_hold_q;
    assign col_err  = col_err_q;
    assign ovr_err  = ovr_err_q;

`ifdef HUB75_OE_MONITOR_EN
    logic [15:0] oe_cnt_q, oe_last_q;

    // Count OE-low cycles per row period; publish and restart on every latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_cnt_q  <= '0;
            oe_last_q <= '0;
        end else if (lat_rise) begin
            oe_last_q <= oe_cnt_q;
            oe_cnt_q  <= '0;
        end else if (!oe_s && oe_cnt_q != 16'hFFFF) begin
            oe_cnt_q <= oe_cnt_q + 16'd1;
        end
    end

    assign oe_on_cycles = oe_last_q;
`else
    logic unused_oe;
    assign unused_oe    = oe_s;
    assign oe_on_cycles = '0;
`endif

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Scoreboard bench for hub75_rx_capture: the driver pushes expected pixel
// writes as rows are issued, a negedge monitor pops and compares each write.
module tb_hub75_rx_capture;

    localparam int COLS = 32;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic SCLK, LAT, OE, A, B, C, D, R0, G0, B0, R1, G1, B1;
    logic        pix_we, frame_done, col_err, ovr_err;
    logic [9:0]  pix_addr;
    logic [2:0]  pix_rgb;
    logic [15:0] oe_on_cycles;

    always #5 clk = ~clk;

    hub75_rx_capture #(.COLS(COLS), .ROWS_HALF(16), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .LAT(LAT), .OE(OE),
        .A(A), .B(B), .C(C), .D(D),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .col_err(col_err), .ovr_err(ovr_err),
        .oe_on_cycles(oe_on_cycles)
    );

    typedef struct packed {
        logic [9:0] addr;
        logic [2:0] rgb;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_n = 0, col_err_n = 0, ovr_err_n = 0, frame_n = 0, burst_len = 0;
    int   hits[1024];
    logic prev_we = 1'b0;
    logic abort_burst = 1'b0;
    logic [9:0] last_addr = '0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every write against the scoreboard, count pulses
    always @(negedge clk) begin
        if (rst) begin
            burst_len = 0;
            prev_we   = 1'b0;
        end else begin
            if (pix_we) begin
                wr_n++;
                burst_len++;
                hits[pix_addr]++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0d rgb %0d, no write expected", pix_addr, pix_rgb);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_addr", int'(pix_addr), int'(mon_e.addr));
                    check("pix_rgb", int'(pix_rgb), int'(mon_e.rgb));
                end
                last_addr = pix_addr;
            end else if (prev_we) begin
                if (!abort_burst) check("burst_len", burst_len, 2 * COLS);
                burst_len = 0;
            end
            if (col_err) col_err_n++;
            if (ovr_err) ovr_err_n++;
            if (frame_done) begin
                frame_n++;
                check("frame_done_timing", int'(prev_we && !pix_we && last_addr == 10'd1023), 1);
            end
            prev_we = pix_we;
        end
    end

    function automatic logic [5:0] word_of(int seed, int k);
        if (seed < 0) return (k % 2 == 0) ? 6'b101010 : 6'b010101;
        return 6'(seed * 11 + k * 5 + (k >> 2));
    endfunction

    task automatic push_row(int row, int seed);
        logic [5:0] w;
        for (int c = 0; c < COLS; c++) begin
            w = word_of(seed, COLS - 1 - c);
            exp_q.push_back({10'(row * COLS + c), w[5:3]});
        end
        for (int c = 0; c < COLS; c++) begin
            w = word_of(seed, COLS - 1 - c);
            exp_q.push_back({10'((row + 16) * COLS + c), w[2:0]});
        end
    endtask

    task automatic shift_word(logic [5:0] w);
        @(negedge clk);
        {R0, G0, B0, R1, G1, B1} = w;
        SCLK = 1'b0;
        @(negedge clk);
        @(negedge clk);
        SCLK = 1'b1;
        @(negedge clk);
    endtask

    task automatic latch(int row);
        @(negedge clk);
        SCLK = 1'b0;
        {D, C, B, A} = 4'(row);
        @(negedge clk);
        LAT = 1'b1;
        @(negedge clk);
        @(negedge clk);
        LAT = 1'b0;
    endtask

    task automatic send_row(int row, int n, int seed, bit valid);
        for (int k = 0; k < n; k++) shift_word(word_of(seed, k));
        if (valid) push_row(row, seed);
        latch(row);
    endtask

    task automatic wait_drained();
        int t = 0;
        while ((exp_q.size() != 0 || pix_we) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_within_budget", int'(t < 2000), 1);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad_addr, wr_base, wr_at_rst;

        // Reset with random bus activity: all outputs zero
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {SCLK, LAT, OE, D, C, B, A, R0, G0, B0, R1, G1, B1} = 13'($urandom);
            #1;
            check("reset_outputs", int'({pix_we, pix_addr, pix_rgb, frame_done, col_err, ovr_err, oe_on_cycles}), 0);
        end
        @(negedge clk);
        {SCLK, LAT, D, C, B, A, R0, G0, B0, R1, G1, B1} = '0;
        OE = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_writes", wr_n, 0);
        check("idle_col_err", col_err_n, 0);
        check("idle_ovr_err", ovr_err_n, 0);
        check("idle_frame_done", frame_n, 0);

        // Single row 3, alternating pattern; measure first-write latency
        for (int k = 0; k < COLS; k++) shift_word(word_of(-1, k));
        push_row(3, -1);
        @(negedge clk);
        SCLK = 1'b0;
        {D, C, B, A} = 4'd3;
        @(negedge clk);
        LAT = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (pix_we) break;
        end
        LAT = 1'b0;
        check("first_write_latency", n, SYNC + 1);
        wait_drained();
        check("single_row_writes", wr_n, 64);
        check("addr96_hit", hits[96], 1);
        check("addr639_hit", hits[639], 1);

        // Short row, long row, then a good row
        send_row(7, 31, 5, 1'b0);
        repeat (20) @(negedge clk);
        check("short_col_err", col_err_n, 1);
        send_row(7, 33, 5, 1'b0);
        repeat (20) @(negedge clk);
        check("long_col_err", col_err_n, 2);
        check("bad_rows_no_writes", wr_n, 64);
        send_row(9, 32, 6, 1'b1);
        wait_drained();
        check("good_after_bad_writes", wr_n, 128);

        // Two full frames: every address written exactly twice
        for (int i = 0; i < 1024; i++) hits[i] = 0;
        wr_base = wr_n;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 16; r++) send_row(r, 32, 20 + r + 16 * f, 1'b1);
        wait_drained();
        check("frame_writes", wr_n - wr_base, 2048);
        check("frame_done_count", frame_n, 2);
        bad_addr = 0;
        for (int i = 0; i < 1024; i++) if (hits[i] != 2) bad_addr++;
        check("frame_addr_coverage", bad_addr, 0);
        check("frame_no_ovr", ovr_err_n, 0);

        // Overrun: the next row is shifted at full rate during the drain and
        // latched together with its 32nd shift, while the drain is still running
        wr_base = wr_n;
        for (int k = 0; k < COLS; k++) shift_word(word_of(50, k));
        push_row(2, 50);
        @(negedge clk);
        SCLK = 1'b0;
        {D, C, B, A} = 4'd2;
        @(negedge clk);
        LAT = 1'b1;
        for (int k = 0; k < COLS; k++) begin
            @(negedge clk);
            {R0, G0, B0, R1, G1, B1} = word_of(51, k);
            SCLK = 1'b1;
            LAT  = (k == COLS - 1);
            @(negedge clk);
            SCLK = 1'b0;
        end
        @(negedge clk);
        LAT = 1'b0;
        wait_drained();
        check("ovr_err_count", ovr_err_n, 1);
        check("ovr_no_col_err", col_err_n, 2);
        check("ovr_writes", wr_n - wr_base, 64);
        send_row(4, 32, 60, 1'b1);
        wait_drained();
        check("after_ovr_writes", wr_n - wr_base, 128);

        // Reset during a drain: writes stop at once and the row is lost
        for (int k = 0; k < COLS; k++) shift_word(word_of(70, k));
        push_row(6, 70);
        latch(6);
        n = 0;
        while (burst_len < 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_write_20", int'(burst_len >= 20), 1);
        abort_burst = 1'b1;
        #1 rst = 1'b1;
        #1 check("we_drops_on_reset", int'(pix_we), 0);
        exp_q.delete();
        wr_at_rst = wr_n;
        repeat (3) @(negedge clk);
        check("we_held_in_reset", int'(pix_we), 0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("no_writes_after_reset", wr_n, wr_at_rst);
        abort_burst = 1'b0;

        // OE monitor: 500 OE-low cycles between two valid latches
        send_row(1, 32, 80, 1'b1);
        wait_drained();
        @(negedge clk);
        OE = 1'b0;
        repeat (500) @(negedge clk);
        OE = 1'b1;
        send_row(11, 32, 81, 1'b1);
        wait_drained();
`ifdef HUB75_OE_MONITOR_EN
        check("oe_on_cycles", int'(oe_on_cycles), 500);
`else
        check("oe_on_cycles", int'(oe_on_cycles), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
